// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer.
// Build option CARD_DEALER_SHOE_EN (used by card_dealer) selects the finite shoe.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_NONE = 4'd0;
  localparam card_t RANK_ACE  = 4'd1;
  localparam card_t RANK_KING = 4'd13;

  localparam int NUM_RANKS = 13;
  // Per-rank stock width: holds 4 x NUM_DECKS for up to 15 decks.
  localparam int COUNT_W   = 6;
  // Whole-shoe count width: holds 52 x NUM_DECKS for up to 15 decks.
  localparam int LEFT_W    = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DEAL   = 2'd2
  } dealer_state_t;

  // Cards of one rank in a full shoe.
  function automatic logic [COUNT_W-1:0] cards_per_rank(input int num_decks);
    return COUNT_W'(4 * num_decks);
  endfunction

  // Next rank in the A..K cycle, wrapping K back to A.
  function automatic card_t next_rank(input card_t rank);
    return (rank == RANK_KING) ? RANK_ACE : card_t'(rank + 4'd1);
  endfunction

endpackage

// File: rtl/card_dealer_rank_counter.sv
// Rank counter cycling 1..13. Used both as the free-running entropy source
// and, with load/advance, as the probe pointer during a search.
module rank_counter
  import card_pkg::*;
(
  input  logic  fast_clock,
  input  logic  reset,
  input  logic  load,
  input  card_t load_value,
  input  logic  advance,
  output card_t value
);

  card_t value_reg;

  // Load takes priority over advance; reset parks the counter on the ace.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      value_reg <= RANK_ACE;
    end else if (load) begin
      value_reg <= load_value;
    end else if (advance) begin
      value_reg <= next_rank(value_reg);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: returns one rank per request, chosen by sampling a free-running
// rank counter. Define CARD_DEALER_SHOE_EN for a finite shoe with per-rank
// stock; without it the deck is infinite and every request deals the sample.
module card_dealer
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 8
)
(
  input  logic              fast_clock,
  input  logic              reset,
  input  logic              deal_req,
  input  logic              shuffle,
  output card_t             new_card,
  output logic              card_valid,
  output logic              busy,
  output logic              shoe_empty,
  output logic [LEFT_W-1:0] cards_left
);

  dealer_state_t state_reg;
  dealer_state_t state_next;
  card_t         rank_now;
  card_t         probe_value;
  card_t         new_card_reg;
  logic          accept;
  logic          probe_hit;
  logic          probe_advance;
  logic          shuffle_take;
  logic          last_miss;

  // A refill in the same cycle as a request wins; the request is dropped.
  assign accept        = (state_reg == IDLE) && deal_req && !shuffle_take;
  assign probe_advance = (state_reg == SEARCH) && !probe_hit;

  // Free-running source of randomness, advancing every cycle.
  rank_counter u_free_counter (
    .fast_clock (fast_clock),
    .reset      (reset),
    .load       (1'b0),
    .load_value (RANK_ACE),
    .advance    (1'b1),
    .value      (rank_now)
  );

  // Probe pointer: captures the sample on accept, steps past empty ranks.
  rank_counter u_probe (
    .fast_clock (fast_clock),
    .reset      (reset),
    .load       (accept),
    .load_value (rank_now),
    .advance    (probe_advance),
    .value      (probe_value)
  );

`ifdef CARD_DEALER_SHOE_EN

  localparam logic [COUNT_W-1:0] FULL_COUNT = cards_per_rank(NUM_DECKS);
  localparam logic [LEFT_W-1:0]  FULL_SHOE  = LEFT_W'(52 * NUM_DECKS);

  logic [COUNT_W-1:0]   count_reg [NUM_RANKS];
  logic [NUM_RANKS-1:0] rank_stocked;
  logic [3:0]           miss_cnt_reg;
  logic [LEFT_W-1:0]    cards_left_reg;
  logic                 shoe_empty_reg;
  logic                 take_card;

  assign shuffle_take = (state_reg == IDLE) && shuffle;
  assign probe_hit    = rank_stocked[probe_value - RANK_ACE];
  assign take_card    = (state_reg == SEARCH) && probe_hit;
  // Twelve misses already seen, so the current miss is the thirteenth.
  assign last_miss    = (miss_cnt_reg == 4'(NUM_RANKS - 1));

  generate
    for (genvar gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
      assign rank_stocked[gi] = (count_reg[gi] != '0);

      // Per-rank stock: refilled on reset/shuffle, drained one card per deal.
      always_ff @(posedge fast_clock) begin
        if (reset || shuffle_take) begin
          count_reg[gi] <= FULL_COUNT;
        end else if (take_card && (probe_value == card_t'(gi + 1))) begin
          count_reg[gi] <= count_reg[gi] - COUNT_W'(1);
        end
      end
    end
  endgenerate

  // Consecutive empty probes within the current search.
  always_ff @(posedge fast_clock) begin
    if (reset || accept) begin
      miss_cnt_reg <= '0;
    end else if (probe_advance) begin
      miss_cnt_reg <= miss_cnt_reg + 4'd1;
    end
  end

  // Shoe totals, updated on the same edge that loads new_card.
  always_ff @(posedge fast_clock) begin
    if (reset || shuffle_take) begin
      cards_left_reg <= FULL_SHOE;
      shoe_empty_reg <= 1'b0;
    end else begin
      if (take_card) begin
        cards_left_reg <= cards_left_reg - LEFT_W'(1);
      end
      if (probe_advance && last_miss) begin
        shoe_empty_reg <= 1'b1;
      end
    end
  end

  assign cards_left = cards_left_reg;
  assign shoe_empty = shoe_empty_reg;

`else

  // Infinite deck: the first probe always hits and shuffle has no effect.
  assign shuffle_take = 1'b0;
  assign probe_hit    = 1'b1;
  assign last_miss    = 1'b0;
  assign cards_left   = '0;
  assign shoe_empty   = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, shuffle, cards_per_rank(NUM_DECKS)};

`endif

  // Controller state register.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one probe per SEARCH cycle, one DEAL cycle per card.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SEARCH;
      SEARCH: begin
        if (probe_hit) begin
          state_next = DEAL;
        end else if (last_miss) begin
          state_next = IDLE;
        end
      end
      DEAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Dealt rank holds until the next successful probe.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      new_card_reg <= CARD_NONE;
    end else if ((state_reg == SEARCH) && probe_hit) begin
      new_card_reg <= probe_value;
    end
  end

  assign new_card   = new_card_reg;
  assign card_valid = (state_reg == DEAL);
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer. Follows CARD_DEALER_SHOE_EN so that the
// same bench covers both the infinite deck and the finite shoe.
module tb_card_dealer;
  import card_pkg::*;

  localparam int ND = 8;
`ifdef CARD_DEALER_SHOE_EN
  localparam bit SHOE = 1'b1;
`else
  localparam bit SHOE = 1'b0;
`endif
  localparam int FULL_RANK = 4 * ND;
  localparam int FULL_SHOE = 52 * ND;

  logic        fast_clock = 1'b0;
  logic        reset      = 1'b1;
  logic        deal_req   = 1'b0;
  logic        shuffle    = 1'b0;
  card_t       new_card;
  logic        card_valid;
  logic        busy;
  logic        shoe_empty;
  logic [9:0]  cards_left;

  card_dealer #(.NUM_DECKS(ND)) dut (
    .fast_clock (fast_clock),
    .reset      (reset),
    .deal_req   (deal_req),
    .shuffle    (shuffle),
    .new_card   (new_card),
    .card_valid (card_valid),
    .busy       (busy),
    .shoe_empty (shoe_empty),
    .cards_left (cards_left)
  );

  always #5 fast_clock = ~fast_clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cyc counts edges; "cycle c" is the interval after edge c. A request
  // accepted at edge N with k skipped ranks deals at edge N+1+k (card_valid
  // during cycle N+1+k) and leaves the dealer free from cycle N+2+k.
  int cyc         = 0;
  int m_ctr       = 1;
  int m_cnt [13];
  int m_left      = FULL_SHOE;
  bit m_empty     = 1'b0;
  int m_card      = 0;
  int m_free_at   = 0;
  int m_valid_cyc = -1;
  int m_pend_cyc  = -1;
  int m_pend_card = 0;
  bit m_started   = 1'b0;

  always @(posedge fast_clock) begin : model
    automatic int k = 0;
    automatic int rank = 0;
    cyc <= cyc + 1;
    if (reset) begin
      m_started   <= 1'b1;
      m_ctr       <= 1;
      foreach (m_cnt[i]) m_cnt[i] <= FULL_RANK;
      m_left      <= FULL_SHOE;
      m_empty     <= 1'b0;
      m_card      <= 0;
      m_free_at   <= 0;
      m_valid_cyc <= -1;
      m_pend_cyc  <= -1;
    end else begin
      m_ctr <= (m_ctr == 13) ? 1 : m_ctr + 1;
      if (cyc + 1 == m_pend_cyc) begin
        if (m_pend_card == 0) begin
          m_empty <= 1'b1;
        end else begin
          m_card <= m_pend_card;
          m_left <= m_left - 1;
        end
      end
      if (cyc >= m_free_at) begin
        if (SHOE && shuffle) begin
          foreach (m_cnt[i]) m_cnt[i] <= FULL_RANK;
          m_left  <= FULL_SHOE;
          m_empty <= 1'b0;
        end else if (deal_req) begin
          if (SHOE) begin
            while (k < 13 && m_cnt[(m_ctr - 1 + k) % 13] == 0) k++;
          end
          if (k < 13) begin
            rank = (m_ctr - 1 + k) % 13 + 1;
            if (SHOE) m_cnt[rank-1] <= m_cnt[rank-1] - 1;
            m_pend_cyc  <= cyc + 2 + k;
            m_pend_card <= rank;
            m_valid_cyc <= cyc + 2 + k;
            m_free_at   <= cyc + 3 + k;
          end else begin
            m_pend_cyc  <= cyc + 14;
            m_pend_card <= 0;
            m_free_at   <= cyc + 14;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge fast_clock) begin
    if (m_started) begin
      chk("busy",       busy,       (cyc < m_free_at) ? 1 : 0);
      chk("card_valid", card_valid, (cyc == m_valid_cyc) ? 1 : 0);
      chk("new_card",   new_card,   m_card);
      chk("shoe_empty", shoe_empty, SHOE ? int'(m_empty) : 0);
      chk("cards_left", cards_left, SHOE ? m_left : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge fast_clock);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && cyc < m_free_at; i++) tick();
    if (cyc < m_free_at) chk("idle_wait", busy, 0);
  endtask

  task automatic wait_ctr(input int v);
    for (int i = 0; i < 14 && m_ctr != v; i++) tick();
  endtask

  // Request at counter value v; returns at the negedge after acceptance.
  task automatic deal_at(input int v);
    wait_idle();
    wait_ctr(v);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
  endtask

  int last_card;

  initial begin
    // Reset and reset values.
    tick(); tick();
    reset = 1'b0;
    chk("rst_new_card",   new_card,   0);
    chk("rst_card_valid", card_valid, 0);
    chk("rst_busy",       busy,       0);
    chk("rst_shoe_empty", shoe_empty, 0);
    chk("rst_cards_left", cards_left, SHOE ? 416 : 0);

    // First deal at counter 5; requests held while busy are ignored.
    wait_ctr(5);
    deal_req = 1'b1;
    tick();
    chk("d5_busy",  busy,       1);
    chk("d5_early", card_valid, 0);
    tick();
    chk("d5_valid", card_valid, 1);
    chk("d5_card",  new_card,   5);
    chk("d5_left",  cards_left, SHOE ? 415 : 0);
    tick();
    deal_req = 1'b0;
    chk("d5_no_queue", busy, 0);

    // Request at counter 13, then back-to-back deals across the wrap.
    deal_at(13);
    tick();
    chk("d13_card", new_card, 13);
    deal_req = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    deal_req = 1'b0;
    wait_idle();

`ifdef CARD_DEALER_SHOE_EN
    // Drain rank 7, then a request at 7 must skip to 8 in 3 cycles.
    for (int i = 0; i < 40 && m_cnt[6] > 0; i++) deal_at(7);
    deal_at(7);
    chk("r7_skip_busy", card_valid, 0);
    tick();
    chk("r7_skip_wait", card_valid, 0);
    tick();
    chk("r7_skip_valid", card_valid, 1);
    chk("r7_skip_card",  new_card,   8);

    // Drain the whole shoe, then a request must find nothing.
    wait_idle();
    deal_req = 1'b1;
    for (int i = 0; i < 8000 && m_left > 0; i++) tick();
    deal_req = 1'b0;
    chk("drain_left", cards_left, 0);
    wait_idle();
    last_card = m_card;
    chk("drain_not_empty", shoe_empty, 0);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    chk("empty_flag", shoe_empty, 1);
    chk("empty_busy", busy,       0);
    chk("empty_card", new_card,   last_card);
`endif

    // Shuffle together with a request: refill wins when the shoe exists.
    wait_idle();
    shuffle  = 1'b1;
    deal_req = 1'b1;
    tick();
    shuffle  = 1'b0;
    deal_req = 1'b0;
    chk("shuf_busy",  busy,       SHOE ? 0 : 1);
    chk("shuf_empty", shoe_empty, 0);
    chk("shuf_left",  cards_left, SHOE ? 416 : int'(cards_left));
    deal_at(2);
    tick();
    chk("shuf_deal_valid", card_valid, 1);
    chk("shuf_deal_card",  new_card,   2);
    chk("shuf_deal_left",  cards_left, SHOE ? 415 : 0);

    // Reset during SEARCH kills the in-flight request and refills counts.
    deal_at(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_valid", card_valid, 0);
    chk("rs_card",  new_card,   0);
    chk("rs_busy",  busy,       0);
    chk("rs_left",  cards_left, SHOE ? 416 : 0);
    deal_at(9);
    tick();
    chk("rs_deal_card", new_card,   9);
    chk("rs_deal_left", cards_left, SHOE ? 415 : 0);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
